seg_scan_decoder: RTL and testbench

//  Receive-side decoder for a multiplexed, active-low 7-segment display bus: the

---
 rtl/seg_scan_decoder.sv | 243 ++++++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
//
// Receive-side decoder for a multiplexed, active-low 7-segment display bus.
// The segment and anode lines are registered every cycle. When exactly one
// anode is low and the {anode, segment} pattern has held for STABLE_CYCLES
// consecutive samples, the pattern is captured once for the selected digit and
// decoded back to BCD.
//
// Parameters:
//   NUM_DIGITS     number of scanned digits (anodes), >= 1
//   STABLE_CYCLES  consecutive equal samples required before a capture, >= 1
//
// Ports:
//   clk          clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   seg_n[6:0]   segments, active-low, seg_n[0]=a ... seg_n[6]=g
//   an_n[N-1:0]  digit enables, active-low, an_n[i] low selects digit i
//   clr_err      synchronous clear of err_invalid
//   bcd_out      digit i at bcd_out[4i+3:4i]; 4'hF blank/reset, 4'hE invalid
//   digit_valid  digit i last captured a legal 0-9 pattern
//   frame_valid  one-cycle pulse once every digit has been captured
//   err_invalid  sticky flag, set when an illegal non-blank pattern is captured
// -----------------------------------------------------------------------------
module seg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [6:0]                seg_n,
    input  logic [NUM_DIGITS-1:0]     an_n,
    input  logic                      clr_err,
    output logic [4*NUM_DIGITS-1:0]   bcd_out,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic                      frame_valid,
    output logic                      err_invalid
);

    localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
    localparam int KEY_W = NUM_DIGITS + 7;
    localparam int LOW_W = $clog2(NUM_DIGITS + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE   = 2'd1,
        CAPTURED = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input sampling
    // ------------------------------------------------------------------
    logic [6:0]            s_seg_reg;
    logic [NUM_DIGITS-1:0] s_an_reg;
    logic [KEY_W-1:0]      key_q_reg;
    logic [KEY_W-1:0]      key;

    assign key = {s_an_reg, s_seg_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_seg_reg <= 7'h7F;
            s_an_reg  <= '1;
            key_q_reg <= '1;
        end else begin
            s_seg_reg <= seg_n;
            s_an_reg  <= an_n;
            key_q_reg <= key;
        end
    end

    // ------------------------------------------------------------------
    // Anode qualification: exactly one digit selected
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] sel;
    logic [LOW_W-1:0]      low_cnt;
    logic                  one_hot;

    assign sel = ~s_an_reg;

    always_comb begin
        low_cnt = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            low_cnt = low_cnt + LOW_W'(sel[i]);
        end
    end

    assign one_hot = (low_cnt == LOW_W'(1));

    // ------------------------------------------------------------------
    // Settle / capture FSM
    // ------------------------------------------------------------------
    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             key_same;
    logic             capture;

    assign key_same = (key == key_q_reg);

    // The capture decision uses the same terms as the FSM below, so a
    // capture happens exactly on the edge the FSM enters CAPTURED.
    assign capture = one_hot && key_same && (state_reg == SETTLE) && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else if (!one_hot) begin
            // Blanking interval or overlapping anodes: nothing to decode.
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else if (!key_same) begin
            state_reg <= SETTLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg <= SETTLE;
                    cnt_reg   <= '0;
                end
                SETTLE: begin
                    if (cnt_reg == CNT_LAST) begin
                        state_reg <= CAPTURED;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                CAPTURED: begin
                    // Held pattern: one capture per stable key.
                    state_reg <= CAPTURED;
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Segment pattern decode
    // ------------------------------------------------------------------
    logic [3:0] dec_value;
    logic       dec_legal;
    logic       dec_blank;

    always_comb begin
        dec_value = 4'hE;
        dec_legal = 1'b1;
        dec_blank = 1'b0;
        case (s_seg_reg)
            7'h40: dec_value = 4'd0;
            7'h79: dec_value = 4'd1;
            7'h24: dec_value = 4'd2;
            7'h30: dec_value = 4'd3;
            7'h19: dec_value = 4'd4;
            7'h12: dec_value = 4'd5;
            7'h02: dec_value = 4'd6;
            7'h78: dec_value = 4'd7;
            7'h00: dec_value = 4'd8;
            7'h10: dec_value = 4'd9;
            7'h7F: begin
                dec_value = 4'hF;
                dec_legal = 1'b0;
                dec_blank = 1'b1;
            end
            default: begin
                dec_value = 4'hE;
                dec_legal = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-digit result registers
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] nib_reg;
            logic       valid_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    nib_reg   <= 4'hF;
                    valid_reg <= 1'b0;
                end else if (capture && sel[gi]) begin
                    // dec_value already carries F for blank and E for invalid.
                    nib_reg   <= dec_value;
                    valid_reg <= dec_legal;
                end
            end

            assign bcd_out[4*gi +: 4] = nib_reg;
            assign digit_valid[gi]    = valid_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Frame tracking
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] mask_reg;
    logic                  frame_valid_reg;
    logic [NUM_DIGITS-1:0] cap_bits;

    assign cap_bits = capture ? sel : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_reg        <= '0;
            frame_valid_reg <= 1'b0;
        end else if (&mask_reg) begin
            // Pulse and restart; a capture landing now opens the next frame.
            frame_valid_reg <= 1'b1;
            mask_reg        <= cap_bits;
        end else begin
            frame_valid_reg <= 1'b0;
            mask_reg        <= mask_reg | cap_bits;
        end
    end

    assign frame_valid = frame_valid_reg;

    // ------------------------------------------------------------------
    // Sticky error flag; a new error outranks a simultaneous clear.
    // ------------------------------------------------------------------
    logic err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (capture && !dec_legal && !dec_blank) begin
            err_reg <= 1'b1;
        end else if (clr_err) begin
            err_reg <= 1'b0;
        end
    end

    assign err_invalid = err_reg;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_decoder
//
// Two instances: dut0 (STABLE_CYCLES=8) and dut1 (STABLE_CYCLES=1), both with
// four digits. Directed stimulus pushes expected output snapshots, tagged with
// the cycle at which they must be observed, into a queue; a monitor on the
// falling edge pops and compares them. Expected frame pulses go into a second
// queue and every frame_valid pulse on dut0 must match one entry.
// -----------------------------------------------------------------------------
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr_err = 1'b0;
    logic [6:0]  seg_n = 7'h7F;
    logic [3:0]  an_n = 4'hF;
    logic [6:0]  seg1_n = 7'h7F;
    logic [3:0]  an1_n = 4'hF;
    logic        clr1 = 1'b0;

    logic [15:0] bcd0, bcd1;
    logic [3:0]  dv0, dv1;
    logic        fv0, fv1;
    logic        err0, err1;

    seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .an_n(an_n), .clr_err(clr_err),
        .bcd_out(bcd0), .digit_valid(dv0), .frame_valid(fv0), .err_invalid(err0)
    );

    seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .seg_n(seg1_n), .an_n(an1_n), .clr_err(clr1),
        .bcd_out(bcd1), .digit_valid(dv1), .frame_valid(fv1), .err_invalid(err1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        int          cyc;
        int          which;
        logic [15:0] bcd;
        logic [3:0]  dv;
        logic        err;
        bit          chk_fv;
    } exp_t;

    exp_t sq[$];
    int   fq[$];

    // Expected-state model, one per instance.
    logic [15:0] m_bcd [2];
    logic [3:0]  m_dv  [2];
    logic        m_err [2];

    task automatic chk(input string name, input int which, input logic [31:0] got,
                       input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h expected=%0h", name, which, cyc, got, want);
        end
    endtask

    task automatic push_state(input int which, input int at, input bit chk_fv);
        exp_t e;
        e.cyc    = at;
        e.which  = which;
        e.bcd    = m_bcd[which];
        e.dv     = m_dv[which];
        e.err    = m_err[which];
        e.chk_fv = chk_fv;
        sq.push_back(e);
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            m_bcd[w] = 16'hFFFF;
            m_dv[w]  = 4'h0;
            m_err[w] = 1'b0;
        end
    endtask

    // Called just after a rising edge p. Drives the pattern, which is first
    // sampled on edge p+1, so a capture lands on edge p+2+S.
    task automatic hold(input int which, input logic [6:0] seg, input logic [3:0] an,
                        input int n, input bit cap, input int dig, input logic [3:0] nib,
                        input bit dvb, input bit errb, input bit frame);
        int s;
        int p;
        s = (which == 0) ? 8 : 1;
        p = cyc;
        if (which == 0) begin
            seg_n = seg;
            an_n  = an;
        end else begin
            seg1_n = seg;
            an1_n  = an;
        end
        if (cap) begin
            push_state(which, p + 1 + s, 1'b0);
            m_bcd[which][4*dig +: 4] = nib;
            m_dv[which][dig]         = dvb;
            if (errb) m_err[which] = 1'b1;
            push_state(which, p + 2 + s, 1'b0);
            if (frame) fq.push_back(p + 3 + s);
            if (n > s + 2) push_state(which, p + n, 1'b0);
        end else begin
            push_state(which, p + n, 1'b0);
        end
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        exp_t e;
        logic [15:0] g_bcd;
        logic [3:0]  g_dv;
        logic        g_err;
        logic        g_fv;
        while (sq.size() > 0 && sq[0].cyc <= cyc) begin
            e = sq.pop_front();
            if (e.cyc < cyc) begin
                tests_run++;
                tests_failed++;
                $display("FAIL late_check dut%0d cyc=%0d got=missed expected=cyc %0d", e.which, cyc, e.cyc);
            end else begin
                g_bcd = (e.which == 0) ? bcd0 : bcd1;
                g_dv  = (e.which == 0) ? dv0  : dv1;
                g_err = (e.which == 0) ? err0 : err1;
                g_fv  = (e.which == 0) ? fv0  : fv1;
                chk("bcd_out", e.which, 32'(g_bcd), 32'(e.bcd));
                chk("digit_valid", e.which, 32'(g_dv), 32'(e.dv));
                chk("err_invalid", e.which, 32'(g_err), 32'(e.err));
                if (e.chk_fv) chk("frame_valid", e.which, 32'(g_fv), 32'h0);
                $display("[TB] cyc %0d dut%0d bcd=%04h dv=%h err=%0b (expected %04h %h %0b)",
                         cyc, e.which, g_bcd, g_dv, g_err, e.bcd, e.dv, e.err);
            end
        end
        if (fv0 === 1'b1) begin
            tests_run++;
            if (fq.size() > 0 && fq[0] == cyc) begin
                void'(fq.pop_front());
                $display("[TB] cyc %0d dut0 frame_valid pulse as expected", cyc);
            end else begin
                tests_failed++;
                $display("FAIL frame_unexpected dut0 cyc=%0d got=1 expected=0", cyc);
            end
        end
        if (fq.size() > 0 && fq[0] < cyc) begin
            tests_run++;
            tests_failed++;
            $display("FAIL frame_missing dut0 cyc=%0d got=0 expected=pulse at cyc %0d", cyc, fq[0]);
            void'(fq.pop_front());
        end
    end

    initial begin
        int guard;
        model_reset();

        // Power-up reset values.
        repeat (3) @(posedge clk);
        #1;
        push_state(0, cyc, 1'b1);
        push_state(1, cyc, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Digit 0 shows 3, captured exactly after latency, then held with no change.
        hold(0, 7'h30, 4'b1110, 30, 1'b1, 0, 4'h3, 1'b1, 1'b0, 1'b0);

        // Digit 1: 4 for only 5 cycles (no capture), then 5 held.
        hold(0, 7'h19, 4'b1101, 5,  1'b0, 0, 4'h0, 1'b0, 1'b0, 1'b0);
        hold(0, 7'h12, 4'b1101, 12, 1'b1, 1, 4'h5, 1'b1, 1'b0, 1'b0);
        // Two anodes low: never captured.
        hold(0, 7'h12, 4'b1001, 20, 1'b0, 0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Full scan 1,2,3,4; frame completes on digit 3.
        hold(0, 7'h79, 4'b1110, 10, 1'b1, 0, 4'h1, 1'b1, 1'b0, 1'b0);
        hold(0, 7'h24, 4'b1101, 10, 1'b1, 1, 4'h2, 1'b1, 1'b0, 1'b0);
        hold(0, 7'h30, 4'b1011, 10, 1'b1, 2, 4'h3, 1'b1, 1'b0, 1'b0);
        hold(0, 7'h19, 4'b0111, 10, 1'b1, 3, 4'h4, 1'b1, 1'b0, 1'b1);

        // Invalid pattern on digit 2, then blank, then clear the sticky flag.
        hold(0, 7'h7E, 4'b1011, 10, 1'b1, 2, 4'hE, 1'b0, 1'b1, 1'b0);
        hold(0, 7'h7F, 4'b1011, 10, 1'b1, 2, 4'hF, 1'b0, 1'b0, 1'b0);
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        m_err[0] = 1'b0;
        push_state(0, cyc, 1'b0);

        // Invalid capture on the same edge as clr_err: the set wins.
        begin
            int p;
            p = cyc;
            seg_n = 7'h7E;
            an_n  = 4'b1011;
            push_state(0, p + 9, 1'b0);
            m_bcd[0][11:8] = 4'hE;
            m_err[0] = 1'b1;
            push_state(0, p + 10, 1'b0);
            repeat (9) @(posedge clk);
            #1;
            clr_err = 1'b1;
            @(posedge clk);
            #1;
            clr_err = 1'b0;
        end
        hold(0, 7'h7F, 4'b1111, 5, 1'b0, 0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Reset asserted while digit 0 is settling; pending capture discarded.
        seg_n = 7'h40;
        an_n  = 4'b1110;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        seg_n = 7'h7F;
        an_n  = 4'hF;
        model_reset();
        push_state(0, cyc, 1'b1);
        push_state(1, cyc, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(0, 7'h7F, 4'b1111, 12, 1'b0, 0, 4'h0, 1'b0, 1'b0, 1'b0);

        // STABLE_CYCLES=1 instance: capture at edge E+2.
        hold(1, 7'h78, 4'b0111, 6, 1'b1, 3, 4'h7, 1'b1, 1'b0, 1'b0);
        hold(1, 7'h10, 4'b0111, 3, 1'b1, 3, 4'h9, 1'b1, 1'b0, 1'b0);
        hold(1, 7'h00, 4'b1110, 2, 1'b1, 0, 4'h8, 1'b1, 1'b0, 1'b0);
        hold(1, 7'h7F, 4'b1111, 5, 1'b0, 0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Drain outstanding expectations with a bounded wait.
        guard = 0;
        while ((sq.size() > 0 || fq.size() > 0) && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        if (sq.size() > 0 || fq.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain_timeout got=%0d pending expected=0 pending", sq.size() + fq.size());
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
